// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and line-level constants for the write-back UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int   BYTES_PER_WORD = 4;
    localparam int   DATA_BITS      = 8;
    localparam logic START_LVL      = 1'b0;
    localparam logic STOP_LVL       = 1'b1;
    localparam logic IDLE_LVL       = 1'b1;

endpackage

// File: rtl/salida_uart_tx_if.sv
// rtl/salida_uart_tx_if.sv - capture strobe, serial line and FIFO status bundle
interface salida_uart_tx_if #(
    parameter int ADDR_W = 2
);
    logic [31:0]     dato_i;
    logic            valid_i;
    logic            tx_o;
    logic            busy_o;
    logic            empty_o;
    logic            full_o;
    logic [ADDR_W:0] count_o;
    logic            ovf_o;

    modport master (
        output dato_i, valid_i,
        input  tx_o, busy_o, empty_o, full_o, count_o, ovf_o
    );

    modport slave (
        input  dato_i, valid_i,
        output tx_o, busy_o, empty_o, full_o, count_o, ovf_o
    );
endinterface

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with occupancy count, pointers wrap modulo DEPTH
module fifo_sync #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // Head is read combinationally so a pop-and-load happens in a single edge.
    assign dout  = mem[rd_ptr];
    assign full  = (count == (ADDR_W+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/salida_uart_tx.sv
// rtl/salida_uart_tx.sv - buffers write-back words and sends each as four 8N1 bytes, MSB byte first
module salida_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    salida_uart_tx_if.slave  bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              ovf_q;
    logic              tick;
    logic              pop;
    logic              push;
    logic [31:0]       fifo_dout;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = bus.valid_i & (~fifo_full | pop);

    fifo_sync #(
        .WIDTH  (32),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .din    (bus.dato_i),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign tick = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        tx_d    = IDLE_LVL;

        if (state_q != IDLE) begin
            baud_d = tick ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    byte_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
                    else                            bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_q != 2'(BYTES_PER_WORD - 1)) begin
                        byte_d  = byte_q + 1'b1;
                        shreg_d = shreg_q << 8;
                        state_d = START;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        byte_d  = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the next state so tx_o moves on the same edge as the FSM.
        case (state_d)
            START:   tx_d = START_LVL;
            DATA:    tx_d = shreg_d[5'd24 + 5'(bit_d)];
            STOP:    tx_d = STOP_LVL;
            default: tx_d = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            tx_q    <= IDLE_LVL;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            if (bus.valid_i && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    assign bus.tx_o    = tx_q;
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.empty_o = fifo_empty;
    assign bus.full_o  = fifo_full;
    assign bus.count_o = fifo_count;
    assign bus.ovf_o   = ovf_q;
endmodule

// File: tb/tb_salida_uart_tx.sv
// tb/tb_salida_uart_tx.sv - directed and randomized checks of salida_uart_tx against a line-level model
module tb_salida_uart_tx;
    localparam int CA = 4;
    localparam int CB = 434;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    salida_uart_tx_if #(.ADDR_W(2)) bus_a ();
    salida_uart_tx_if #(.ADDR_W(2)) bus_b ();

    salida_uart_tx #(.CLKS_PER_BIT(CA), .DEPTH(4), .ADDR_W(2)) dut_a (
        .clk_i (clk), .rst_ni (rst_ni), .bus (bus_a)
    );
    salida_uart_tx #(.CLKS_PER_BIT(CB), .DEPTH(4), .ADDR_W(2)) dut_b (
        .clk_i (clk), .rst_ni (rst_ni), .bus (bus_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line history indexed by the edge number that produced each value.
    bit ha_tx [65536];
    bit ha_busy [65536];
    bit hb_tx [65536];
    bit hb_busy [65536];
    always @(negedge clk) begin
        ha_tx[cyc & 65535]   <= bus_a.tx_o;
        ha_busy[cyc & 65535] <= bus_a.busy_o;
        hb_tx[cyc & 65535]   <= bus_b.tx_o;
        hb_busy[cyc & 65535] <= bus_b.busy_o;
    end

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic hist_tx(input bit use_b, input int i);
        return use_b ? hb_tx[i & 65535] : ha_tx[i & 65535];
    endfunction

    function automatic logic hist_busy(input bit use_b, input int i);
        return use_b ? hb_busy[i & 65535] : ha_busy[i & 65535];
    endfunction

    // Ideal line level k cycles after the first start bit for the words in exp_q.
    function automatic logic exp_bit(input int k, input int c);
        int w, r, by, bi;
        logic [31:0] x;
        w  = k / (40 * c);
        r  = k % (40 * c);
        by = r / (10 * c);
        bi = (r % (10 * c)) / c;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        x = exp_q[w] >> (8 * (3 - by));
        return x[bi - 1];
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        bus_b.valid_i = 1'b0;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input bit use_b, input int n, output int e0);
        e0 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) e0 = cyc + 1;
            if (use_b) begin
                bus_b.valid_i = 1'b1;
                bus_b.dato_i  = exp_q[i];
            end else begin
                bus_a.valid_i = 1'b1;
                bus_a.dato_i  = exp_q[i];
            end
        end
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        bus_b.valid_i = 1'b0;
    endtask

    task automatic check_wave(input string tag, input bit use_b, input int e1, input int c);
        int n, bad;
        logic [31:0] w;
        n = exp_q.size() * 40 * c;
        wait_until(e1 + n + 2);
        bad = 0;
        for (int k = 0; k < n; k++) begin
            if (hist_tx(use_b, e1 + k) !== exp_bit(k, c)) bad++;
        end
        check({tag, " wave_errors"}, bad, 0);
        for (int wi = 0; wi < exp_q.size(); wi++) begin
            w = '0;
            for (int by = 0; by < 4; by++) begin
                for (int b = 0; b < 8; b++) begin
                    w[8 * (3 - by) + b] = hist_tx(use_b, e1 + wi * 40 * c + by * 10 * c + (1 + b) * c + c / 2);
                end
            end
            check($sformatf("%s word%0d", tag, wi), w, exp_q[wi]);
        end
        check({tag, " busy_last"}, hist_busy(use_b, e1 + n - 1), 1);
        check({tag, " busy_after"}, hist_busy(use_b, e1 + n), 0);
        check({tag, " tx_after"}, hist_tx(use_b, e1 + n), 1);
    endtask

    initial begin
        int e0, bad, n, run;
        logic prev;
        bus_a.valid_i = 1'b0;
        bus_a.dato_i  = '0;
        bus_b.valid_i = 1'b0;
        bus_b.dato_i  = '0;
        rst_ni = 1'b1;

        // Asynchronous reset before any clock edge.
        #2 rst_ni = 1'b0;
        #1;
        check("rst tx_a", bus_a.tx_o, 1);
        check("rst busy_a", bus_a.busy_o, 0);
        check("rst empty_a", bus_a.empty_o, 1);
        check("rst full_a", bus_a.full_o, 0);
        check("rst count_a", bus_a.count_o, 0);
        check("rst ovf_a", bus_a.ovf_o, 0);
        check("rst tx_b", bus_b.tx_o, 1);
        check("rst busy_b", bus_b.busy_o, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        exp_q.delete();
        exp_q.push_back(32'h12345678);
        push(1'b0, 1, e0);
        check_wave("single", 1'b0, e0 + 1, CA);

        do_reset();
        exp_q.delete();
        exp_q.push_back(32'hFF00FF00);
        exp_q.push_back(32'h0000FFFF);
        push(1'b0, 2, e0);
        check_wave("b2b", 1'b0, e0 + 1, CA);

        // Six pushes into a four-deep FIFO: the sixth word is dropped.
        do_reset();
        exp_q.delete();
        for (int i = 1; i <= 5; i++) exp_q.push_back(32'(i));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) e0 = cyc + 1;
            if (i == 2) begin
                check("ovf busy_e1", bus_a.busy_o, 1);
                check("ovf count_e1", bus_a.count_o, 1);
            end
            if (i == 5) begin
                check("ovf count_e4", bus_a.count_o, 4);
                check("ovf flag_e4", bus_a.ovf_o, 0);
            end
            bus_a.valid_i = 1'b1;
            bus_a.dato_i  = 32'(i + 1);
        end
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        check("ovf flag_e5", bus_a.ovf_o, 1);
        check("ovf count_e5", bus_a.count_o, 4);
        check("ovf full_e5", bus_a.full_o, 1);
        check_wave("ovf", 1'b0, e0 + 1, CA);
        check("ovf sticky", bus_a.ovf_o, 1);

        // Push on exactly the edge that pops the next word while full.
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back($urandom);
        push(1'b0, 5, e0);
        wait_until(e0 + 160);
        check("fullpp full_before", bus_a.full_o, 1);
        bus_a.valid_i = 1'b1;
        bus_a.dato_i  = exp_q[5];
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        check("fullpp count", bus_a.count_o, 4);
        check("fullpp ovf", bus_a.ovf_o, 0);
        check_wave("fullpp", 1'b0, e0 + 1, CA);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            n = $urandom_range(1, 5);
            exp_q.delete();
            for (int i = 0; i < n; i++) exp_q.push_back($urandom);
            push(1'b0, n, e0);
            check_wave($sformatf("rand%0d", r), 1'b0, e0 + 1, CA);
            check($sformatf("rand%0d ovf", r), bus_a.ovf_o, 0);
        end

        // Reset while a zero data bit of the third byte is on the line.
        do_reset();
        exp_q.delete();
        exp_q.push_back($urandom & 32'hFFFF00FF);
        exp_q.push_back($urandom);
        push(1'b0, 2, e0);
        wait_until(e0 + 1 + 90);
        check("midrst tx_before", bus_a.tx_o, 0);
        check("midrst busy_before", bus_a.busy_o, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst tx", bus_a.tx_o, 1);
        check("midrst count", bus_a.count_o, 0);
        check("midrst busy", bus_a.busy_o, 0);
        check("midrst empty", bus_a.empty_o, 1);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus_a.tx_o !== 1'b1 || bus_a.busy_o !== 1'b0) bad++;
        end
        check("midrst idle_cycles_bad", bad, 0);

        do_reset();
        exp_q.delete();
        exp_q.push_back(32'h55AA0001);
        push(1'b1, 1, e0);
        check_wave("baud434", 1'b1, e0 + 1, CB);
        bad = 0;
        run = 0;
        prev = hist_tx(1'b1, e0 + 1);
        for (int k = 0; k < 40 * CB; k++) begin
            if (hist_tx(1'b1, e0 + 1 + k) !== prev) begin
                if (run % CB != 0) bad++;
                run = 0;
                prev = hist_tx(1'b1, e0 + 1 + k);
            end
            run++;
        end
        check("baud434 run_length_bad", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
